key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_conditioner_if.sv | 21 ++
 rtl/key_conditioner.sv | 148 ++++++++++++++
 tb/tb_key_conditioner.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_conditioner_if.sv
// Key conditioner signal bundle: raw active-low buttons in, conditioned pulses and levels out.
`timescale 1ns/1ps
interface key_conditioner_if;
    logic [3:0] key_n;
    logic       mode_key_n;
    logic       bell_key_n;
    logic [3:0] key_pulse;
    logic       Mode;
    logic       Ctrl_Bell;
    logic [3:0] key_held;

    modport master (
        output key_n, mode_key_n, bell_key_n,
        input  key_pulse, Mode, Ctrl_Bell, key_held
    );

    modport slave (
        input  key_n, mode_key_n, bell_key_n,
        output key_pulse, Mode, Ctrl_Bell, key_held
    );
endinterface

// File: rtl/key_conditioner.sv
// Six-button conditioner for a clock: synchronize, debounce, press/auto-repeat pulses
// on the four adjust keys, and toggle levels for the mode and alarm-enable keys.
`timescale 1ns/1ps
module key_conditioner #(
    parameter int DEB_CYCLES    = 20,
    parameter int HOLD_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 200
) (
    input logic              CP,
    input logic              nCR,
    key_conditioner_if.slave bus
);
    localparam int NUM_CH  = 6;
    localparam int NUM_KEY = 4;
    localparam int CH_MODE = 4;
    localparam int CH_BELL = 5;
    localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES);
    localparam logic [RPT_W-1:0] HOLD_LAST = RPT_W'(HOLD_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_LAST  = RPT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_REPEAT
    } key_state_e;

    // Channel order: [3:0] adjust keys, [4] mode, [5] bell; all active-high "pressed".
    logic [NUM_CH-1:0]  raw_pressed;
    logic [NUM_CH-1:0]  sync_q1;
    logic [NUM_CH-1:0]  sync_q2;
    logic [NUM_CH-1:0]  deb_q;
    logic [NUM_CH-1:0]  differ;
    logic [NUM_CH-1:0]  flip;
    logic [NUM_CH-1:0]  press_evt;
    logic [NUM_KEY-1:0] release_evt;
    logic [DEB_W-1:0]   deb_cnt_q [NUM_CH];
    key_state_e         state_q   [NUM_KEY];
    logic [RPT_W-1:0]   rpt_cnt_q [NUM_KEY];
    logic [NUM_KEY-1:0] pulse_q;
    logic               mode_q;
    logic               bell_q;

    assign raw_pressed = ~{bus.bell_key_n, bus.mode_key_n, bus.key_n};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= raw_pressed;
            sync_q2 <= sync_q1;
        end
    end

    // The level flips on the edge where a full run of differing samples has been counted.
    always_comb begin
        differ = '0;
        flip   = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            differ[ch] = sync_q2[ch] ^ deb_q[ch];
            flip[ch]   = differ[ch] && (deb_cnt_q[ch] == DEB_LAST);
        end
        press_evt   = flip & ~deb_q;
        release_evt = flip[NUM_KEY-1:0] & deb_q[NUM_KEY-1:0];
    end

    // NOTE: these register arrays are a handful of counters, not RAM, so they are reset in a loop.
    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            deb_q <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) deb_cnt_q[ch] <= '0;
        end else begin
            deb_q <= deb_q ^ flip;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (!differ[ch] || flip[ch]) deb_cnt_q[ch] <= '0;
                else                         deb_cnt_q[ch] <= deb_cnt_q[ch] + DEB_W'(1);
            end
        end
    end

    // Release takes priority, so a repeat pulse due on the release edge is dropped.
    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            pulse_q <= '0;
            for (int k = 0; k < NUM_KEY; k++) begin
                state_q[k]   <= ST_IDLE;
                rpt_cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_KEY; k++) begin
                pulse_q[k] <= 1'b0;
                if (release_evt[k]) begin
                    state_q[k]   <= ST_IDLE;
                    rpt_cnt_q[k] <= '0;
                end else begin
                    case (state_q[k])
                        ST_IDLE: begin
                            if (press_evt[k]) begin
                                state_q[k]   <= ST_PRESSED;
                                rpt_cnt_q[k] <= '0;
                                pulse_q[k]   <= 1'b1;
                            end
                        end
                        ST_PRESSED: begin
                            if (rpt_cnt_q[k] == HOLD_LAST) begin
                                state_q[k]   <= ST_REPEAT;
                                rpt_cnt_q[k] <= '0;
                                pulse_q[k]   <= 1'b1;
                            end else begin
                                rpt_cnt_q[k] <= rpt_cnt_q[k] + RPT_W'(1);
                            end
                        end
                        ST_REPEAT: begin
                            if (rpt_cnt_q[k] == RPT_LAST) begin
                                rpt_cnt_q[k] <= '0;
                                pulse_q[k]   <= 1'b1;
                            end else begin
                                rpt_cnt_q[k] <= rpt_cnt_q[k] + RPT_W'(1);
                            end
                        end
                        default: state_q[k] <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            mode_q <= 1'b0;
            bell_q <= 1'b0;
        end else begin
            if (press_evt[CH_MODE]) mode_q <= ~mode_q;
            if (press_evt[CH_BELL]) bell_q <= ~bell_q;
        end
    end

    assign bus.key_pulse = pulse_q;
    assign bus.key_held  = deb_q[NUM_KEY-1:0];
    assign bus.Mode      = mode_q;
    assign bus.Ctrl_Bell = bell_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed scenarios plus random key activity,
// compared every cycle against a sample-history reference model.
`timescale 1ns/1ps
module tb_key_conditioner;
    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;
    localparam int HL   = DEB + 3;

    logic CP = 1'b0;
    logic nCR;
    key_conditioner_if bus ();

    key_conditioner #(
        .DEB_CYCLES   (DEB),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP)
    ) dut (
        .CP (CP),
        .nCR(nCR),
        .bus(bus)
    );

    always #5 CP = ~CP;

    int tests   = 0;
    int fails   = 0;
    int edge_no = 0;

    // Reference model: raw samples per edge, newest at index 0.
    bit         hist      [6][HL];
    bit         m_deb     [6];
    int         m_press_t [4];
    logic [3:0] m_pulse;
    logic       m_mode;
    logic       m_bell;

    typedef struct {
        int ch;
        int at;
    } pulse_rec_t;
    pulse_rec_t plog[$];
    int   bell_toggle_at = -1;
    logic prev_bell      = 1'b0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, edge_no);
        end
    endtask

    function automatic void model_reset();
        for (int ch = 0; ch < 6; ch++) begin
            m_deb[ch] = 1'b0;
            for (int j = 0; j < HL; j++) hist[ch][j] = 1'b0;
        end
        for (int k = 0; k < 4; k++) m_press_t[k] = 0;
        m_pulse = '0;
        m_mode  = 1'b0;
        m_bell  = 1'b0;
    endfunction

    // A level changes once DEB+1 consecutive samples, seen two edges late, disagree with it.
    function automatic void model_edge(logic [5:0] pressed);
        bit flp [6];
        int d;
        for (int ch = 0; ch < 6; ch++) begin
            for (int j = HL - 1; j > 0; j--) hist[ch][j] = hist[ch][j-1];
            hist[ch][0] = pressed[ch];
            flp[ch] = 1'b1;
            for (int j = 2; j <= DEB + 2; j++)
                if (hist[ch][j] == m_deb[ch]) flp[ch] = 1'b0;
        end
        m_pulse = '0;
        for (int k = 0; k < 4; k++) begin
            if (flp[k] && !m_deb[k]) begin
                m_pulse[k]   = 1'b1;
                m_press_t[k] = edge_no;
            end else if (m_deb[k] && !flp[k]) begin
                d = edge_no - m_press_t[k];
                if (d == HOLD || (d > HOLD && (d - HOLD) % REP == 0)) m_pulse[k] = 1'b1;
            end
        end
        if (flp[4] && !m_deb[4]) m_mode = ~m_mode;
        if (flp[5] && !m_deb[5]) m_bell = ~m_bell;
        for (int ch = 0; ch < 6; ch++)
            if (flp[ch]) m_deb[ch] = ~m_deb[ch];
    endfunction

    task automatic check_all(string tag);
        check({tag, "_pulse"}, bus.key_pulse, m_pulse);
        check({tag, "_held"},  bus.key_held, {m_deb[3], m_deb[2], m_deb[1], m_deb[0]});
        check({tag, "_mode"},  bus.Mode, m_mode);
        check({tag, "_bell"},  bus.Ctrl_Bell, m_bell);
    endtask

    task automatic set_keys(logic [5:0] pressed);
        {bus.bell_key_n, bus.mode_key_n, bus.key_n} = ~pressed;
    endtask

    task automatic tick();
        logic [5:0] pressed;
        pressed = ~{bus.bell_key_n, bus.mode_key_n, bus.key_n};
        @(posedge CP);
        model_edge(pressed);
        #1;
        check_all("run");
        for (int k = 0; k < 4; k++)
            if (bus.key_pulse[k] === 1'b1) plog.push_back('{k, edge_no});
        if (bus.Ctrl_Bell !== prev_bell) bell_toggle_at = edge_no;
        prev_bell = bus.Ctrl_Bell;
        edge_no++;
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    // Asserts nCR just after an edge, checks the immediate clear, holds for n edges.
    task automatic do_reset(int n);
        nCR = 1'b0;
        model_reset();
        #1;
        check_all("reset_async");
        repeat (n) begin
            @(posedge CP);
            #1;
            check_all("reset_hold");
        end
        prev_bell = 1'b0;
        @(negedge CP);
        nCR = 1'b1;
    endtask

    function automatic int count_pulses(int ch, int from);
        int c = 0;
        foreach (plog[i]) if (plog[i].ch == ch && plog[i].at >= from) c++;
        return c;
    endfunction

    function automatic int nth_pulse(int ch, int from, int n);
        int c = 0;
        foreach (plog[i]) begin
            if (plog[i].ch == ch && plog[i].at >= from) begin
                if (c == n) return plog[i].at;
                c++;
            end
        end
        return -1;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int p;
        int len;
        logic [5:0] mask;
        int exp_rel [8] = '{6, 16, 19, 22, 25, 28, 31, 34};

        nCR = 1'b1;
        set_keys('0);
        model_reset();
        #1;
        do_reset(2);
        run(10);

        // Single short press: one pulse at +6, nothing on release.
        t0 = edge_no;
        set_keys(6'b000001);
        run(8);
        set_keys('0);
        run(12);
        check("req023_count", count_pulses(0, t0), 1);
        check("req023_edge", nth_pulse(0, t0, 0) - t0, 6);

        // Bouncing input shorter than the debounce window.
        t0 = edge_no;
        repeat (5) begin
            set_keys(6'b000010);
            run(3);
            set_keys('0);
            run(1);
        end
        run(10);
        check("req024_count", count_pulses(1, t0), 0);
        check("req024_held", bus.key_held[1], 1'b0);

        // Long hold: press, hold pulse, then repeat pulses until debounced release.
        t0 = edge_no;
        set_keys(6'b000100);
        run(30);
        set_keys('0);
        run(15);
        check("req025_count", count_pulses(2, t0), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("req025_pulse%0d", i), nth_pulse(2, t0, i) - t0, exp_rel[i]);

        // Mode toggles once per press, never on release, never repeats.
        for (int i = 0; i < 3; i++) begin
            set_keys(6'b010000);
            run(6);
            set_keys('0);
            run(6);
            check($sformatf("req026_mode%0d", i), bus.Mode, (i % 2 == 0) ? 1'b1 : 1'b0);
        end
        set_keys(6'b010000);
        run(50);
        set_keys('0);
        run(10);
        check("req026_long_hold", bus.Mode, 1'b0);

        // Reset during hold and during repeat; key still held counts as a new press.
        set_keys(6'b001000);
        run(13);
        do_reset(2);
        t0 = edge_no;
        run(25);
        check("req027_first", nth_pulse(3, t0, 0) - t0, 6);
        check("req027_hold", nth_pulse(3, t0, 1) - t0, 16);
        do_reset(3);
        t0 = edge_no;
        run(10);
        check("req027_again", nth_pulse(3, t0, 0) - t0, 6);
        check("req027_single", count_pulses(3, t0), 1);
        set_keys('0);
        run(12);

        // Simultaneous adjust key and bell key.
        t0 = edge_no;
        set_keys(6'b100001);
        run(10);
        p = nth_pulse(0, t0, 0);
        check("req028_pulse", p - t0, 6);
        check("req028_same_cycle", bell_toggle_at, p);
        check("req028_bell", bus.Ctrl_Bell, 1'b1);
        set_keys('0);
        run(10);

        // Random key activity, with occasional resets.
        repeat (200) begin
            mask = 6'($urandom);
            len  = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 7);
            set_keys(mask);
            run(len);
            if ($urandom_range(0, 49) == 0) do_reset($urandom_range(1, 3));
        end
        set_keys('0);
        run(15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
